// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: conditions the push-button, requests a red phase
// from traffic_light and sequences the WALK / flashing DON'T-WALK lamps with safety aborts.
module ped_crossing_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WALK_CYCLES     = 20,
    parameter int FLASH_CYCLES    = 10,
    parameter int FLASH_HALF      = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic red,
    input  logic green,
    input  logic yellow,
    output logic ped_req,
    output logic walk,
    output logic dont_walk,
    output logic fault
);

    localparam int MAX_CYC = (WALK_CYCLES > FLASH_CYCLES) ? WALK_CYCLES : FLASH_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FH_W    = $clog2(FLASH_HALF + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RED,
        ST_WALK,
        ST_FLASH
    } state_t;

    state_t            state_q,     state_d;
    logic              s1_q,        s1_d;
    logic              s2_q,        s2_d;
    logic              stable_q,    stable_d;
    logic [DB_W-1:0]   db_cnt_q,    db_cnt_d;
    logic              press_q,     press_d;
    logic              red_q,       red_d;
    logic              pending_q,   pending_d;
    logic [TMR_W-1:0]  timer_q,     timer_d;
    logic [FH_W-1:0]   flash_cnt_q, flash_cnt_d;
    logic              ped_req_q,   ped_req_d;
    logic              walk_q,      walk_d;
    logic              dont_walk_q, dont_walk_d;
    logic              fault_q,     fault_d;

    logic lamps_legal;
    logic fresh_red;
    logic in_crossing;

    assign lamps_legal = ({red, green, yellow} == 3'b100) ||
                         ({red, green, yellow} == 3'b010) ||
                         ({red, green, yellow} == 3'b001);
    assign fresh_red   = red & ~red_q;
    assign in_crossing = (state_q == ST_WALK) || (state_q == ST_FLASH);

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        s1_d        = btn;
        s2_d        = s1_q;
        stable_d    = stable_q;
        db_cnt_d    = '0;
        red_d       = red;
        pending_d   = pending_q;
        timer_d     = timer_q;
        flash_cnt_d = flash_cnt_q;
        ped_req_d   = ped_req_q;
        walk_d      = walk_q;
        dont_walk_d = dont_walk_q;
        fault_d     = 1'b0;

        // Debouncer: accept s2 only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
        if (s2_q != stable_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = s2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        press_d = stable_d & ~stable_q;

        if (!lamps_legal || (in_crossing && !red)) begin
            // Safety abort outranks timer expiry and presses.
            state_d     = ST_IDLE;
            ped_req_d   = 1'b0;
            pending_d   = 1'b0;
            walk_d      = 1'b0;
            dont_walk_d = 1'b1;
            timer_d     = '0;
            flash_cnt_d = '0;
            fault_d     = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (press_q || pending_q) begin
                        state_d   = ST_WAIT_RED;
                        ped_req_d = 1'b1;
                        pending_d = 1'b0;
                    end
                end
                ST_WAIT_RED: begin
                    if (fresh_red) begin
                        state_d     = ST_WALK;
                        ped_req_d   = 1'b0;
                        walk_d      = 1'b1;
                        dont_walk_d = 1'b0;
                        timer_d     = TMR_W'(WALK_CYCLES - 1);
                    end
                end
                ST_WALK: begin
                    if (press_q) begin
                        pending_d = 1'b1;
                    end
                    if (timer_q == '0) begin
                        state_d     = ST_FLASH;
                        walk_d      = 1'b0;
                        dont_walk_d = 1'b0;
                        timer_d     = TMR_W'(FLASH_CYCLES - 1);
                        flash_cnt_d = FH_W'(FLASH_HALF - 1);
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                ST_FLASH: begin
                    if (press_q) begin
                        pending_d = 1'b1;
                    end
                    if (timer_q == '0) begin
                        state_d     = ST_IDLE;
                        dont_walk_d = 1'b1;
                        flash_cnt_d = '0;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                        if (flash_cnt_q == '0) begin
                            dont_walk_d = ~dont_walk_q;
                            flash_cnt_d = FH_W'(FLASH_HALF - 1);
                        end else begin
                            flash_cnt_d = flash_cnt_q - FH_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            stable_q    <= 1'b0;
            db_cnt_q    <= '0;
            press_q     <= 1'b0;
            red_q       <= 1'b1;  // a red already lit at reset release is not fresh
            pending_q   <= 1'b0;
            timer_q     <= '0;
            flash_cnt_q <= '0;
            ped_req_q   <= 1'b0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            stable_q    <= stable_d;
            db_cnt_q    <= db_cnt_d;
            press_q     <= press_d;
            red_q       <= red_d;
            pending_q   <= pending_d;
            timer_q     <= timer_d;
            flash_cnt_q <= flash_cnt_d;
            ped_req_q   <= ped_req_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            fault_q     <= fault_d;
        end
    end

    assign ped_req   = ped_req_q;
    assign walk      = walk_q;
    assign dont_walk = dont_walk_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Self-checking bench for ped_crossing_ctrl: reset/press vector table, hand-written
// crossing corner cases, then random traffic checked against a phase/elapsed-time model.
module tb_ped_crossing_ctrl;

    localparam int DEB    = 4;
    localparam int WALKC  = 20;
    localparam int FLASHC = 10;
    localparam int HALF   = 2;

    logic clk = 1'b0;
    logic rst, btn, red, green, yellow;
    logic ped_req, walk, dont_walk, fault;

    ped_crossing_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .WALK_CYCLES    (WALKC),
        .FLASH_CYCLES   (FLASHC),
        .FLASH_HALF     (HALF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .red      (red),
        .green    (green),
        .yellow   (yellow),
        .ped_req  (ped_req),
        .walk     (walk),
        .dont_walk(dont_walk),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: crossing phase plus cycles elapsed in that phase.
    localparam int P_IDLE = 0, P_WAIT = 1, P_WALK = 2, P_FLASH = 3;
    bit m_s1, m_s2, m_stable, m_press, m_red_prev, m_pending, m_req, m_fault;
    int m_run, m_phase, m_elapsed;

    function automatic bit m_walk();
        return m_phase == P_WALK;
    endfunction

    function automatic bit m_dw();
        if (m_phase == P_WALK)  return 1'b0;
        if (m_phase == P_FLASH) return ((m_elapsed / HALF) % 2) == 1;
        return 1'b1;
    endfunction

    task automatic model_step();
        bit legal, fresh, rose, old_s2;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_stable = 0; m_press = 0; m_red_prev = 1;
            m_pending = 0; m_req = 0; m_fault = 0; m_run = 0;
            m_phase = P_IDLE; m_elapsed = 0;
            return;
        end
        legal   = (int'(red) + int'(green) + int'(yellow)) == 1;
        fresh   = red && !m_red_prev;
        m_fault = 0;
        if (!legal || ((m_phase == P_WALK || m_phase == P_FLASH) && !red)) begin
            m_phase = P_IDLE; m_req = 0; m_pending = 0; m_fault = 1;
        end else begin
            case (m_phase)
                P_IDLE: if (m_press || m_pending) begin
                    m_phase = P_WAIT; m_req = 1; m_pending = 0;
                end
                P_WAIT: if (fresh) begin
                    m_phase = P_WALK; m_elapsed = 0; m_req = 0;
                end
                P_WALK: begin
                    if (m_press) m_pending = 1;
                    m_elapsed++;
                    if (m_elapsed == WALKC) begin m_phase = P_FLASH; m_elapsed = 0; end
                end
                default: begin
                    if (m_press) m_pending = 1;
                    m_elapsed++;
                    if (m_elapsed == FLASHC) m_phase = P_IDLE;
                end
            endcase
        end
        old_s2 = m_s2;
        rose   = 0;
        if (old_s2 != m_stable) begin
            m_run++;
            if (m_run == DEB) begin
                m_stable = old_s2; m_run = 0; rose = old_s2;
            end
        end else begin
            m_run = 0;
        end
        m_press    = rose;
        m_s2       = m_s1;
        m_s1       = btn;
        m_red_prev = red;
    endtask

    // One clock: model advances on the edge, DUT outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model_ped_req",   ped_req,   m_req);
        check("model_walk",      walk,      m_walk());
        check("model_dont_walk", dont_walk, m_dw());
        check("model_fault",     fault,     m_fault);
    endtask

    task automatic press_btn();
        btn = 1'b1;
        repeat (10) cycle();
        btn = 1'b0;
        repeat (2) cycle();
    endtask

    typedef struct {
        logic rst, btn, red, green, yellow;
        logic e_req, e_walk, e_dw, e_fault;
    } vec_t;

    vec_t tbl[10];
    logic walk_log[40];
    logic dw_log[40];
    logic req_log[40];
    bit   fl_pat[10] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0};

    initial begin
        rst = 1'b1; btn = 1'b0; red = 1'b0; green = 1'b1; yellow = 1'b0;

        // Reset, then a clean press in the green phase: ped_req rises at edge DEB+3.
        for (int i = 0; i < 10; i++) begin
            tbl[i] = '{rst: (i < 2), btn: (i >= 2), red: 1'b0, green: 1'b1, yellow: 1'b0,
                       e_req: (i >= 8), e_walk: 1'b0, e_dw: 1'b1, e_fault: 1'b0};
        end
        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst; btn = tbl[i].btn; red = tbl[i].red;
            green = tbl[i].green; yellow = tbl[i].yellow;
            cycle();
            check($sformatf("tbl%0d_ped_req", i),   ped_req,   tbl[i].e_req);
            check($sformatf("tbl%0d_walk", i),      walk,      tbl[i].e_walk);
            check($sformatf("tbl%0d_dont_walk", i), dont_walk, tbl[i].e_dw);
            check($sformatf("tbl%0d_fault", i),     fault,     tbl[i].e_fault);
        end

        // Full crossing: fresh red with a pending request.
        btn = 1'b0; red = 1'b1; green = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            walk_log[k] = walk; dw_log[k] = dont_walk; req_log[k] = ped_req;
        end
        check("cross_req_drop", req_log[0], 1'b0);
        for (int k = 0; k < 40; k++) begin
            check($sformatf("cross_walk_%0d", k), walk_log[k], (k < WALKC) ? 1'b1 : 1'b0);
            if (k >= WALKC && k < WALKC + FLASHC)
                check($sformatf("cross_flash_%0d", k - WALKC), dw_log[k], fl_pat[k - WALKC]);
            else if (k >= WALKC + FLASHC)
                check($sformatf("cross_dw_idle_%0d", k), dw_log[k], 1'b1);
        end

        // Bounce rejection.
        rst = 1'b1; red = 1'b0; green = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            btn = (k < 10) ? logic'(k % 2) : 1'b0;
            cycle();
            check("bounce_no_req", ped_req, 1'b0);
        end

        // Stale red: request while red already lit must wait for a new red.
        red = 1'b1; green = 1'b0;
        cycle();
        press_btn();
        check("stale_req_up", ped_req, 1'b1);
        repeat (20) begin
            cycle();
            check("stale_no_walk", walk, 1'b0);
        end
        red = 1'b0; green = 1'b1;
        repeat (2) cycle();
        red = 1'b1; green = 1'b0;
        cycle();
        check("stale_walk_start", walk, 1'b1);
        check("stale_req_drop", ped_req, 1'b0);

        // Red loss 5 cycles into WALK.
        repeat (4) cycle();
        red = 1'b0; green = 1'b1;
        cycle();
        check("loss_walk", walk, 1'b0);
        check("loss_dw", dont_walk, 1'b1);
        check("loss_fault", fault, 1'b1);
        cycle();
        check("loss_fault_once", fault, 1'b0);
        repeat (5) begin
            cycle();
            check("loss_no_req", ped_req, 1'b0);
        end

        // Press during WALK is served on the edge after FLASH ends.
        press_btn();
        red = 1'b1; green = 1'b0;
        cycle();
        check("pend_walk_start", walk, 1'b1);
        for (int k = 1; k <= WALKC + FLASHC + 1; k++) begin
            btn = (k >= 2 && k < 10);
            cycle();
            check($sformatf("pend_req_%0d", k), ped_req, (k == WALKC + FLASHC + 1) ? 1'b1 : 1'b0);
        end

        // Illegal lamps (red and green together) for 3 cycles.
        btn = 1'b0; green = 1'b1;
        repeat (3) begin
            cycle();
            check("illegal_fault", fault, 1'b1);
            check("illegal_req_clear", ped_req, 1'b0);
        end
        red = 1'b0;
        cycle();
        check("illegal_fault_end", fault, 1'b0);
        red = 1'b1; green = 1'b0;
        repeat (5) begin
            cycle();
            check("illegal_idle_walk", walk, 1'b0);
        end

        // Random traffic against the model.
        begin
            int lamp_left = 0;
            int btn_left  = 0;
            for (int n = 0; n < 4000; n++) begin
                if (lamp_left == 0) begin
                    if ($urandom_range(0, 19) == 0) begin
                        {red, green, yellow} = 3'($urandom_range(0, 7));
                        lamp_left = $urandom_range(1, 3);
                    end else begin
                        case ($urandom_range(0, 2))
                            0:       {red, green, yellow} = 3'b100;
                            1:       {red, green, yellow} = 3'b010;
                            default: {red, green, yellow} = 3'b001;
                        endcase
                        lamp_left = $urandom_range(1, 50);
                    end
                end
                lamp_left--;
                if (btn_left == 0) begin
                    btn      = 1'($urandom_range(0, 1));
                    btn_left = $urandom_range(1, 12);
                end
                btn_left--;
                rst = ($urandom_range(0, 499) == 0);
                cycle();
            end
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
